// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: FSM states, SPI mode fields and
// serial bit ordering.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StWait
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Word bit position carried by serial slot cnt (0 = first on the wire).
    function automatic int unsigned bit_idx(input logic        lsb_first,
                                            input int unsigned cnt,
                                            input int unsigned width);
        return lsb_first ? cnt : width - 1 - cnt;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK divider: counts CLK_DIV clk cycles per half period and flags the
// leading/trailing SCLK edges while shifting.
module spi_clkgen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic shift_en,
    output logic tick,
    output logic lead,
    output logic trail
);

    localparam int unsigned CntW = $clog2(CLK_DIV + 1);

    logic [CntW-1:0] cnt_q;
    logic            half_q;

    assign tick  = (cnt_q == CntW'(CLK_DIV - 1));
    assign lead  = tick && shift_en && !half_q;
    assign trail = tick && shift_en && half_q;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_q  <= '0;
            half_q <= 1'b0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CntW'(1);
            if (tick && shift_en) begin
                half_q <= !half_q;
            end
        end
    end

endmodule

// File: rtl/spi_master_p.sv
// Full-duplex SPI master with start/busy/done handshake, selectable bit order
// and back-to-back words under a held chip select.
module spi_master_p
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned NUM_SS  = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        cont,
    input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] cs_sel,
    input  logic [1:0]                                  mode,
    input  logic                                        lsb_first,
    input  logic [DATA_W-1:0]                           tx_data,
    output logic [DATA_W-1:0]                           rx_data,
    output logic                                        busy,
    output logic                                        done,
    output logic [NUM_SS-1:0]                           ss,
    output logic                                        sclk,
    output logic                                        mosi,
    input  logic                                        miso
);

    localparam int unsigned IdxW = $clog2(DATA_W);
    localparam logic [IdxW-1:0] LastBit = IdxW'(DATA_W - 1);

    spi_state_e        state_q;
    spi_mode_t         mode_q;
    logic              lsb_q;
    logic              cont_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic [DATA_W-1:0] rx_q;
    logic [NUM_SS-1:0] ss_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              busy_q;
    logic              done_q;
    logic [IdxW-1:0]   bit_cnt_q;

    logic              tick;
    logic              lead;
    logic              trail;
    logic              restart;
    logic              shift_en;
    logic [IdxW-1:0]   cur_idx;
    logic [IdxW-1:0]   nxt_idx;
    logic [IdxW-1:0]   first_idx;
    logic              sel_ok;

    // Idle-type states hold the divider at zero so every entry starts a fresh count.
    assign restart  = (state_q == StIdle) || (state_q == StWait);
    assign shift_en = (state_q == StShift);

    always_comb begin
        cur_idx   = IdxW'(bit_idx(lsb_q, 32'(bit_cnt_q), DATA_W));
        nxt_idx   = IdxW'(bit_idx(lsb_q, 32'(bit_cnt_q) + 1, DATA_W));
        first_idx = IdxW'(bit_idx(lsb_first, 0, DATA_W));
        sel_ok    = (32'(cs_sel) < NUM_SS);
    end

    spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .shift_en (shift_en),
        .tick     (tick),
        .lead     (lead),
        .trail    (trail)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mode_q    <= '0;
            lsb_q     <= 1'b0;
            cont_q    <= 1'b0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_q      <= '0;
            ss_q      <= '1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    sclk_q <= mode[1];
                    if (start && sel_ok) begin
                        mode_q    <= spi_mode_t'(mode);
                        lsb_q     <= lsb_first;
                        cont_q    <= cont;
                        tx_q      <= tx_data;
                        ss_q      <= ~(NUM_SS'(1) << cs_sel);
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        if (!mode[0]) begin
                            mosi_q <= tx_data[first_idx];
                        end
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    if (tick) begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (lead) begin
                        sclk_q <= !mode_q.cpol;
                        if (mode_q.cpha) begin
                            mosi_q <= tx_q[cur_idx];
                        end else begin
                            rx_sh_q[cur_idx] <= miso;
                        end
                    end
                    if (trail) begin
                        sclk_q <= mode_q.cpol;
                        if (mode_q.cpha) begin
                            rx_sh_q[cur_idx] <= miso;
                        end else if (bit_cnt_q != LastBit) begin
                            mosi_q <= tx_q[nxt_idx];
                        end
                        if (bit_cnt_q == LastBit) begin
                            state_q <= StHold;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + IdxW'(1);
                        end
                    end
                end
                StHold: begin
                    if (tick) begin
                        rx_q   <= rx_sh_q;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        if (cont_q) begin
                            state_q <= StWait;
                        end else begin
                            ss_q    <= '1;
                            state_q <= StIdle;
                        end
                    end
                end
                StWait: begin
                    // A new start outranks a dropped cont; chip select and mode carry over.
                    if (start) begin
                        lsb_q     <= lsb_first;
                        cont_q    <= cont;
                        tx_q      <= tx_data;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        if (!mode_q.cpha) begin
                            mosi_q <= tx_data[first_idx];
                        end
                        state_q   <= StShift;
                    end else if (!cont) begin
                        ss_q    <= '1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_data = rx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ss      = ss_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;

endmodule
